// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-initiator Wishbone arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    // Master indices; also the encoding of the last-grant register.
    localparam logic MST_0 = 1'b0;
    localparam logic MST_1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

    // One master's request-side Wishbone signals.
    typedef struct packed {
        logic              cyc;
        logic              stb;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } wb_req_t;

    // Grant state corresponding to a master index.
    function automatic arb_state_t gnt_state(input logic idx);
        return (idx == MST_1) ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-hang watchdog: counts un-acked cycles of the granted CYC and fires once.
// Latency: fire is combinational in the cycle the count sits at TIMEOUT-1 with no ack.
// Backpressure: none; stall does not pause the count, only an ack clears it.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic s_sys_clk,
    input  logic n_rst,
    input  logic active,
    input  logic ack,
    output logic fire
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic unused_in;
            assign unused_in = ^{s_sys_clk, n_rst, active, ack};
            assign fire      = 1'b0;
        end else begin : g_enabled
            // Firing happens at TIMEOUT-1, so the count never needs to go past it;
            // holding there keeps the counter within TO_W bits even when TIMEOUT == 2^TO_W.
            localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

            logic [TO_W-1:0] cnt;

            // Count un-acked granted cycles; clear on ack or when the grant goes away.
            always_ff @(posedge s_sys_clk or negedge n_rst) begin
                if (!n_rst) begin
                    cnt <= '0;
                end else if (!active || ack) begin
                    cnt <= '0;
                end else if (cnt != CNT_LAST) begin
                    cnt <= cnt + TO_W'(1);
                end
            end

            // An ack in the firing cycle wins over the timeout.
            assign fire = active && !ack && (cnt == CNT_LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master pipelined Wishbone arbiter with per-CYC grant, handover and hang watchdog.
// Latency: one clock from CYC rise to grant; granted path is combinational thereafter.
// Backpressure: granted master sees downstream stall; the other master sees stall=1.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic              s_sys_clk,
    input  logic              n_rst,

    input  logic              i_m0_cyc,
    input  logic              i_m0_stb,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_data,
    input  logic [SEL_W-1:0]  i_m0_sel,
    output logic              o_m0_stall,
    output logic              o_m0_ack,
    output logic              o_m0_err,
    output logic [DATA_W-1:0] o_m0_data,

    input  logic              i_m1_cyc,
    input  logic              i_m1_stb,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_data,
    input  logic [SEL_W-1:0]  i_m1_sel,
    output logic              o_m1_stall,
    output logic              o_m1_ack,
    output logic              o_m1_err,
    output logic [DATA_W-1:0] o_m1_data,

    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [SEL_W-1:0]  o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic [DATA_W-1:0] i_wb_data
);

    arb_state_t state;
    logic       last_gnt;   // master granted most recently
    logic       abort_idx;  // master whose cycle was terminated
    logic       err0;
    logic       err1;

    wb_req_t    m0_req;
    wb_req_t    m1_req;
    wb_req_t    gnt_req;

    logic       in_gnt;
    logic       gnt_idx;
    logic       gnt_cyc;
    logic       oth_cyc;
    logic       abort_cyc;
    logic       wd_fire;

    assign m0_req = '{cyc: i_m0_cyc, stb: i_m0_stb, we: i_m0_we,
                      addr: i_m0_addr, data: i_m0_data, sel: i_m0_sel};
    assign m1_req = '{cyc: i_m1_cyc, stb: i_m1_stb, we: i_m1_we,
                      addr: i_m1_addr, data: i_m1_data, sel: i_m1_sel};

    assign in_gnt    = (state == GNT0) || (state == GNT1);
    assign gnt_idx   = (state == GNT1) ? MST_1 : MST_0;
    assign gnt_req   = (gnt_idx == MST_1) ? m1_req : m0_req;
    assign gnt_cyc   = gnt_req.cyc;
    assign oth_cyc   = (gnt_idx == MST_1) ? i_m0_cyc : i_m1_cyc;
    assign abort_cyc = (abort_idx == MST_1) ? i_m1_cyc : i_m0_cyc;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .s_sys_clk (s_sys_clk),
        .n_rst     (n_rst),
        .active    (in_gnt && gnt_cyc),
        .ack       (i_wb_ack),
        .fire      (wd_fire)
    );

    // Grant FSM: arbitrate in IDLE, hold grant for the whole CYC, hand over directly,
    // and park in ABORT after a watchdog timeout until the stuck master lets go.
    always_ff @(posedge s_sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            last_gnt  <= MST_1;
            abort_idx <= MST_0;
            err0      <= 1'b0;
            err1      <= 1'b0;
        end else begin
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_m0_cyc && i_m1_cyc) begin
                        if ((FAIR != 0) && (last_gnt == MST_0)) begin
                            state    <= GNT1;
                            last_gnt <= MST_1;
                        end else begin
                            state    <= GNT0;
                            last_gnt <= MST_0;
                        end
                    end else if (i_m0_cyc) begin
                        state    <= GNT0;
                        last_gnt <= MST_0;
                    end else if (i_m1_cyc) begin
                        state    <= GNT1;
                        last_gnt <= MST_1;
                    end
                end
                GNT0, GNT1: begin
                    if (wd_fire) begin
                        state     <= ABORT;
                        abort_idx <= gnt_idx;
                        if (gnt_idx == MST_1) begin
                            err1 <= 1'b1;
                        end else begin
                            err0 <= 1'b1;
                        end
                    end else if (!gnt_cyc) begin
                        if (oth_cyc) begin
                            state    <= gnt_state(~gnt_idx);
                            last_gnt <= ~gnt_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ABORT: begin
                    if (!abort_cyc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the granted master to the bus and the bus responses back to it only.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_wb_sel   = '0;
        o_m0_stall = 1'b1;
        o_m0_ack   = 1'b0;
        o_m0_data  = '0;
        o_m1_stall = 1'b1;
        o_m1_ack   = 1'b0;
        o_m1_data  = '0;
        if (in_gnt) begin
            o_wb_cyc  = gnt_req.cyc;
            o_wb_stb  = gnt_req.stb;
            o_wb_we   = gnt_req.we;
            o_wb_addr = gnt_req.addr;
            o_wb_data = gnt_req.data;
            o_wb_sel  = gnt_req.sel;
            if (gnt_idx == MST_1) begin
                o_m1_stall = i_wb_stall;
                o_m1_ack   = i_wb_ack;
                o_m1_data  = i_wb_data;
            end else begin
                o_m0_stall = i_wb_stall;
                o_m0_ack   = i_wb_ack;
                o_m0_data  = i_wb_data;
            end
        end
    end

    // Error pulses are registered and only ever high in the first ABORT cycle,
    // where ack is forced low, so ack and err never coincide.
    assign o_m0_err = err0;
    assign o_m1_err = err1;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: fair instance with a short watchdog plus a fixed-priority instance.
// Latency: checks one-clock arbitration and combinational pass-through.
// Backpressure: exercises downstream stall and blocked second master.
module tb_wb_master_arbiter;

    logic        s_sys_clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_addr = 0, m0_wdat = 0;
    logic [3:0]  m0_sel = 0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_addr = 0, m1_wdat = 0;
    logic [3:0]  m1_sel = 0;
    logic        wb_stall = 0, wb_ack = 0;
    logic [31:0] wb_rdat = 0;

    logic        o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err;
    logic [31:0] o_m0_data, o_m1_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic [3:0]  o_wb_sel;

    logic        fp_m0_stall, fp_m0_ack, fp_m0_err, fp_m1_stall, fp_m1_ack, fp_m1_err;
    logic [31:0] fp_m0_data, fp_m1_data;
    logic        fp_wb_cyc, fp_wb_stb, fp_wb_we;
    logic [31:0] fp_wb_addr, fp_wb_data;
    logic [3:0]  fp_wb_sel;

    int errors = 0;
    int checks = 0;

    always #5 s_sys_clk = ~s_sys_clk;

    wb_master_arbiter #(.FAIR(1), .TIMEOUT(16), .TO_W(5)) dut (
        .s_sys_clk(s_sys_clk), .n_rst(n_rst),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_data(m0_wdat), .i_m0_sel(m0_sel), .o_m0_stall(o_m0_stall), .o_m0_ack(o_m0_ack),
        .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_data(m1_wdat), .i_m1_sel(m1_sel), .o_m1_stall(o_m1_stall), .o_m1_ack(o_m1_ack),
        .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
        .i_wb_data(wb_rdat)
    );

    wb_master_arbiter #(.FAIR(0), .TIMEOUT(0), .TO_W(4)) dut_fp (
        .s_sys_clk(s_sys_clk), .n_rst(n_rst),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_data(m0_wdat), .i_m0_sel(m0_sel), .o_m0_stall(fp_m0_stall), .o_m0_ack(fp_m0_ack),
        .o_m0_err(fp_m0_err), .o_m0_data(fp_m0_data),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_data(m1_wdat), .i_m1_sel(m1_sel), .o_m1_stall(fp_m1_stall), .o_m1_ack(fp_m1_ack),
        .o_m1_err(fp_m1_err), .o_m1_data(fp_m1_data),
        .o_wb_cyc(fp_wb_cyc), .o_wb_stb(fp_wb_stb), .o_wb_we(fp_wb_we), .o_wb_addr(fp_wb_addr),
        .o_wb_data(fp_wb_data), .o_wb_sel(fp_wb_sel), .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
        .i_wb_data(wb_rdat)
    );

    task automatic step_clk();
        @(posedge s_sys_clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_wb_cyc got %b want 0", o_wb_cyc); end
        checks++; if ({o_m0_stall, o_m1_stall} !== 2'b11) begin errors++; $display("FAIL reset_stall got %b want 11", {o_m0_stall, o_m1_stall}); end
        checks++; if ({o_m0_ack, o_m0_err, o_m1_ack, o_m1_err} !== 4'b0) begin errors++; $display("FAIL reset_ack_err got %b want 0000", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}); end
        checks++; if (o_wb_addr !== 32'h0 || o_m0_data !== 32'h0) begin errors++; $display("FAIL reset_addr_data got %h/%h want 0/0", o_wb_addr, o_m0_data); end
        #10 n_rst = 1'b1;
        step_clk();
    endtask

    // Simultaneous requests: fair grants M0, M1, M0 after reset; fixed priority always M0.
    task automatic test_fair();
        logic [31:0] exp_addr [3];
        exp_addr = '{32'h0000_1000, 32'h0000_2001, 32'h0000_1002};
        for (int c = 0; c < 3; c++) begin
            m0_cyc = 1; m0_stb = 1; m0_addr = 32'h1000 + c;
            m1_cyc = 1; m1_stb = 1; m1_addr = 32'h2000 + c;
            #1;
            checks++; if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL fair_idle_%0d got cyc %b want 0", c, o_wb_cyc); end
            step_clk();
            checks++; if (o_wb_addr !== exp_addr[c]) begin errors++; $display("FAIL fair_grant_%0d got %h want %h", c, o_wb_addr, exp_addr[c]); end
            checks++; if (fp_wb_addr !== 32'h1000 + c) begin errors++; $display("FAIL fixed_grant_%0d got %h want %h", c, fp_wb_addr, 32'h1000 + c); end
            checks++; if ((c == 1 ? o_m0_stall : o_m1_stall) !== 1'b1) begin errors++; $display("FAIL fair_loser_stall_%0d got 0 want 1", c); end
            m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
            step_clk();
        end
    endtask

    task automatic test_single_read();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h0001_0000;
        #1;
        checks++; if (o_m0_stall !== 1'b1) begin errors++; $display("FAIL read_pre_grant_stall got %b want 1", o_m0_stall); end
        step_clk();
        checks++; if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1 || o_wb_addr !== 32'h0001_0000) begin
            errors++; $display("FAIL read_grant got cyc %b stb %b addr %h want 1 1 00010000", o_wb_cyc, o_wb_stb, o_wb_addr); end
        checks++; if (o_m0_stall !== 1'b0 || o_m1_stall !== 1'b1) begin errors++; $display("FAIL read_stall got m0 %b m1 %b want 0 1", o_m0_stall, o_m1_stall); end
        step_clk();
        m0_stb = 0; wb_ack = 1; wb_rdat = 32'hDEAD_BEEF;
        #1;
        checks++; if (o_m0_ack !== 1'b1 || o_m0_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_ack got %b %h want 1 deadbeef", o_m0_ack, o_m0_data); end
        checks++; if (o_m1_ack !== 1'b0 || o_m1_data !== 32'h0) begin errors++; $display("FAIL read_m1_isolated got %b %h want 0 0", o_m1_ack, o_m1_data); end
        step_clk();
        wb_ack = 0; wb_rdat = 0; m0_cyc = 0;
        step_clk();
        checks++; if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL read_release got cyc %b want 0", o_wb_cyc); end
    endtask

    // M0 pipelined writes under stall while M1 waits; handover to M1 with no idle cycle.
    task automatic test_back_to_back();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_addr = 32'h100; m0_wdat = 32'h11;
        wb_stall = 1;
        step_clk();
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h200;
        #1;
        checks++; if (o_m0_stall !== 1'b1 || o_wb_addr !== 32'h100 || o_wb_sel !== 4'hF) begin
            errors++; $display("FAIL b2b_stalled got stall %b addr %h sel %h want 1 100 f", o_m0_stall, o_wb_addr, o_wb_sel); end
        step_clk();
        step_clk();
        wb_stall = 0;
        for (int i = 0; i < 5; i++) begin
            m0_stb = (i < 4); m0_addr = 32'h100 + 4 * i; m0_wdat = 32'h11 + i;
            wb_ack = (i > 0); m0_cyc = (i < 4);
            #1;
            if (i > 0) begin
                checks++; if (o_m0_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_%0d got %b want 1", i, o_m0_ack); end
            end
            checks++; if (o_m1_stall !== 1'b1 || o_m1_ack !== 1'b0) begin errors++; $display("FAIL b2b_m1_blocked_%0d got stall %b ack %b want 1 0", i, o_m1_stall, o_m1_ack); end
            step_clk();
        end
        wb_ack = 0; m0_we = 0; m0_sel = 0;
        #1;
        checks++; if (o_wb_cyc !== 1'b1 || o_wb_addr !== 32'h200 || o_m1_stall !== 1'b0) begin
            errors++; $display("FAIL b2b_handover got cyc %b addr %h stall %b want 1 200 0", o_wb_cyc, o_wb_addr, o_m1_stall); end
        m1_cyc = 0; m1_stb = 0;
        step_clk();
        checks++; if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL b2b_release got cyc %b want 0", o_wb_cyc); end
    endtask

    // Unresponsive slave: err on M1 exactly 16 cycles after grant, late ack dropped.
    task automatic test_timeout();
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h300;
        step_clk();
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++; if (o_m1_err !== 1'b0 || o_wb_cyc !== 1'b1) begin errors++; $display("FAIL to_wait_%0d got err %b cyc %b want 0 1", k, o_m1_err, o_wb_cyc); end
            m1_stb = 0;
            step_clk();
        end
        checks++; if (o_m1_err !== 1'b1 || o_wb_cyc !== 1'b0 || o_m1_ack !== 1'b0) begin
            errors++; $display("FAIL to_fire got err %b cyc %b ack %b want 1 0 0", o_m1_err, o_wb_cyc, o_m1_ack); end
        step_clk();
        wb_ack = 1;
        #1;
        checks++; if (o_m1_ack !== 1'b0 || o_m1_err !== 1'b0 || o_m1_stall !== 1'b1) begin
            errors++; $display("FAIL to_late_ack got ack %b err %b stall %b want 0 0 1", o_m1_ack, o_m1_err, o_m1_stall); end
        step_clk();
        wb_ack = 0; m1_cyc = 0;
        step_clk();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h400;
        step_clk();
        checks++; if (o_wb_cyc !== 1'b1 || o_wb_addr !== 32'h400) begin errors++; $display("FAIL to_back_to_idle got cyc %b addr %h want 1 400", o_wb_cyc, o_wb_addr); end
        m0_cyc = 0; m0_stb = 0;
        step_clk();
    endtask

    // Ack in the 16th granted cycle beats the watchdog.
    task automatic test_ack_boundary();
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h500;
        step_clk();
        for (int k = 0; k < 15; k++) begin
            m1_stb = 0;
            step_clk();
        end
        wb_ack = 1; wb_rdat = 32'h1234_5678;
        #1;
        checks++; if (o_m1_ack !== 1'b1 || o_m1_err !== 1'b0 || o_m1_data !== 32'h1234_5678) begin
            errors++; $display("FAIL edge_ack got ack %b err %b data %h want 1 0 12345678", o_m1_ack, o_m1_err, o_m1_data); end
        step_clk();
        wb_ack = 0; wb_rdat = 0;
        #1;
        checks++; if (o_m1_err !== 1'b0 || o_wb_cyc !== 1'b1) begin errors++; $display("FAIL edge_after got err %b cyc %b want 0 1", o_m1_err, o_wb_cyc); end
        m1_cyc = 0;
        step_clk();
    endtask

    // Asynchronous reset mid-burst in GNT1, then tie-breaking restarts with M0.
    task automatic test_reset_mid();
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h600;
        step_clk();
        wb_ack = 1; wb_rdat = 32'hCAFE_F00D;
        #1;
        checks++; if (o_wb_cyc !== 1'b1 || o_m1_ack !== 1'b1) begin errors++; $display("FAIL rst_pre got cyc %b ack %b want 1 1", o_wb_cyc, o_m1_ack); end
        #1 n_rst = 1'b0;
        #1;
        checks++; if (o_wb_cyc !== 1'b0 || o_wb_addr !== 32'h0 || o_m1_stall !== 1'b1 || o_m1_ack !== 1'b0 || o_m1_data !== 32'h0) begin
            errors++; $display("FAIL rst_async got cyc %b addr %h stall %b ack %b data %h want 0 0 1 0 0", o_wb_cyc, o_wb_addr, o_m1_stall, o_m1_ack, o_m1_data); end
        wb_ack = 0; wb_rdat = 0; m1_cyc = 0; m1_stb = 0;
        step_clk();
        #2 n_rst = 1'b1;
        step_clk();
        m0_cyc = 1; m0_addr = 32'h700; m1_cyc = 1; m1_addr = 32'h800;
        step_clk();
        checks++; if (o_wb_addr !== 32'h700) begin errors++; $display("FAIL rst_first_tie got %h want 00000700", o_wb_addr); end
        m0_cyc = 0; m1_cyc = 0;
        step_clk();
        m0_cyc = 1; m1_cyc = 1;
        step_clk();
        checks++; if (o_wb_addr !== 32'h800) begin errors++; $display("FAIL rst_second_tie got %h want 00000800", o_wb_addr); end
        m0_cyc = 0; m1_cyc = 0;
        step_clk();
    endtask

    initial begin
        test_reset();
        test_fair();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_ack_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
